counter_8254: RTL

- One 16-bit binary down-counter channel of the intel8254 top; three instances sit directly downstream of the RW address decoder.
- Each instance is selected by its enable bit and takes data-bus writes, control-word fields, count ticks and its gate.
- Produces OUTn and registered read-back data.
- Supports modes 0, 2 and 3 and the counter-latch command; BCD is not supported.

---
 rtl/i8254_pkg.sv | 29 ++
 rtl/counter_8254_bus.sv | 93 +++++++++
 rtl/counter_8254.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/i8254_pkg.sv
// rtl/i8254_pkg.sv - shared mode/RW encodings and load-state type for the 8254 counter channel
package i8254_pkg;

  localparam logic [2:0] MODE0 = 3'd0;
  localparam logic [2:0] MODE2 = 3'd2;
  localparam logic [2:0] MODE3 = 3'd3;

  localparam logic [1:0] RW_LATCH = 2'b00;
  localparam logic [1:0] RW_LSB   = 2'b01;
  localparam logic [1:0] RW_MSB   = 2'b10;
  localparam logic [1:0] RW_BOTH  = 2'b11;

  // IDLE: no count yet; HALT: mode 0 waiting for MSB; PEND: load on next tick; RUN: counting
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HALT,
    ST_PEND,
    ST_RUN
  } load_state_t;

  function automatic logic [2:0] decode_mode(input logic [2:0] m);
    case (m)
      3'b110:  return MODE2;
      3'b111:  return MODE3;
      default: return m;
    endcase
  endfunction

endpackage

// File: rtl/counter_8254_bus.sv
// rtl/counter_8254_bus.sv - data-bus side of a counter channel: byte pointers, CR assembly,
// output latch and registered read mux
module counter_8254_bus
  import i8254_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_wr_strobe,
  input  logic             i_rd_strobe,
  input  logic             i_ctrl_wr,
  input  logic [1:0]       i_ctrl_rw,
  input  logic [7:0]       i_data_in,
  input  logic [WIDTH-1:0] i_ce,
  output logic [WIDTH-1:0] o_cr,
  output logic             o_wr_done,
  output logic             o_wr_first,
  output logic [7:0]       o_data_out
);

  logic [1:0]       r_rw;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic             r_latched;
  logic [WIDTH-1:0] r_ol;
  logic [WIDTH-1:0] r_cr;
  logic [7:0]       r_data_out;

  logic             w_cw;
  logic             w_latch_cmd;
  logic             w_wr;
  logic             w_rd;
  logic             w_rd_msb;
  logic             w_rd_last;
  logic [WIDTH-1:0] w_src;

  assign w_cw        = i_ctrl_wr && (i_ctrl_rw != RW_LATCH);
  assign w_latch_cmd = i_ctrl_wr && (i_ctrl_rw == RW_LATCH);
  // A control word in the same cycle swallows the data write
  assign w_wr        = i_wr_strobe && i_en && !i_ctrl_wr;
  assign w_rd        = i_rd_strobe && i_en;

  assign o_wr_done  = w_wr && ((r_rw != RW_BOTH) || r_wr_ptr);
  assign o_wr_first = w_wr && (r_rw == RW_BOTH) && !r_wr_ptr;

  assign w_src     = r_latched ? r_ol : i_ce;
  assign w_rd_msb  = (r_rw == RW_MSB) || ((r_rw == RW_BOTH) && r_rd_ptr);
  assign w_rd_last = (r_rw != RW_BOTH) || r_rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rw       <= RW_LSB;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_latched  <= 1'b0;
      r_ol       <= '0;
      r_cr       <= '0;
      r_data_out <= 8'h00;
    end else begin
      if (w_rd) begin
        r_data_out <= w_rd_msb ? w_src[WIDTH-1:8] : w_src[7:0];
        if (r_rw == RW_BOTH) r_rd_ptr <= ~r_rd_ptr;
        if (w_rd_last) r_latched <= 1'b0;
      end
      if (w_wr) begin
        case (r_rw)
          RW_LSB: r_cr <= {8'h00, i_data_in};
          RW_MSB: r_cr <= {i_data_in, 8'h00};
          default: begin
            if (r_wr_ptr) r_cr[WIDTH-1:8] <= i_data_in;
            else          r_cr[7:0]       <= i_data_in;
            r_wr_ptr <= ~r_wr_ptr;
          end
        endcase
      end
      if (w_cw) begin
        r_rw      <= i_ctrl_rw;
        r_wr_ptr  <= 1'b0;
        r_rd_ptr  <= 1'b0;
        r_latched <= 1'b0;
      end else if (w_latch_cmd && !r_latched) begin
        r_ol      <= i_ce;
        r_latched <= 1'b1;
      end
    end
  end

  assign o_cr       = r_cr;
  assign o_data_out = r_data_out;

endmodule

// File: rtl/counter_8254.sv
// rtl/counter_8254.sv - one 8254 counter channel (modes 0/2/3, binary only):
// counting element, load sequencing and OUTn
module counter_8254
  import i8254_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       wr_strobe,
  input  logic       rd_strobe,
  input  logic       ctrl_wr,
  input  logic [1:0] ctrl_rw,
  input  logic [2:0] ctrl_mode,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic       count_tick,
  input  logic       gate,
  output logic       out
);

  load_state_t      r_state;
  load_state_t      w_state_next;
  logic [2:0]       r_mode;
  logic [2:0]       w_mode_dec;
  logic [WIDTH-1:0] r_ce;
  logic [WIDTH-1:0] w_cr;
  logic [WIDTH-1:0] w_m3_sub;
  logic [WIDTH-1:0] w_m3_next;
  logic             r_out;
  logic             r_first;
  logic             r_odd;
  logic             r_gate_reload;
  logic             w_wr_done;
  logic             w_wr_first;
  logic             w_cw;
  logic             w_load;
  logic             w_run_tick;
  logic             w_m3_zero;
  logic             w_sq_mode;

  counter_8254_bus #(.WIDTH(WIDTH)) u_bus (
    .clk         (clk),
    .rst         (rst),
    .i_en        (en),
    .i_wr_strobe (wr_strobe),
    .i_rd_strobe (rd_strobe),
    .i_ctrl_wr   (ctrl_wr),
    .i_ctrl_rw   (ctrl_rw),
    .i_data_in   (data_in),
    .i_ce        (r_ce),
    .o_cr        (w_cr),
    .o_wr_done   (w_wr_done),
    .o_wr_first  (w_wr_first),
    .o_data_out  (data_out)
  );

  assign w_mode_dec = decode_mode(ctrl_mode);
  assign w_cw       = ctrl_wr && (ctrl_rw != RW_LATCH);
  assign w_sq_mode  = (r_mode == MODE2) || (r_mode == MODE3);
  assign w_load     = (r_state == ST_PEND) && count_tick && !w_cw;
  assign w_run_tick = (r_state == ST_RUN) && count_tick && !w_cw;

  // Odd square-wave counts spend one extra tick high: the first step after reload is 1 or 3
  assign w_m3_sub  = (r_first && r_odd) ? (r_out ? WIDTH'(1) : WIDTH'(3)) : WIDTH'(2);
  assign w_m3_next = r_ce - w_m3_sub;
  assign w_m3_zero = (w_m3_next == '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_cw) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_wr_done)                              w_state_next = ST_PEND;
          else if (w_wr_first && (r_mode == MODE0))   w_state_next = ST_HALT;
        end
        ST_HALT: begin
          if (w_wr_done) w_state_next = ST_PEND;
        end
        ST_PEND: begin
          if (w_wr_done)                              w_state_next = ST_PEND;
          else if (w_wr_first && (r_mode == MODE0))   w_state_next = ST_HALT;
          else if (count_tick)                        w_state_next = ST_RUN;
        end
        ST_RUN: begin
          // Modes 2/3 pick up a new CR at their own reload, so only mode 0 re-arms here
          if (r_mode == MODE0) begin
            if (w_wr_done)       w_state_next = ST_PEND;
            else if (w_wr_first) w_state_next = ST_HALT;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ce          <= '0;
      r_mode        <= MODE0;
      r_out         <= 1'b1;
      r_first       <= 1'b0;
      r_odd         <= 1'b0;
      r_gate_reload <= 1'b0;
    end else if (w_cw) begin
      r_mode        <= w_mode_dec;
      r_out         <= (w_mode_dec != MODE0);
      r_gate_reload <= 1'b0;
    end else begin
      if (w_load) begin
        r_ce          <= w_cr;
        r_out         <= (r_mode != MODE0);
        r_first       <= 1'b1;
        r_odd         <= w_cr[0];
        r_gate_reload <= 1'b0;
      end else if (w_run_tick && gate) begin
        case (r_mode)
          MODE0: begin
            r_ce <= r_ce - WIDTH'(1);
            if (r_ce == WIDTH'(1)) r_out <= 1'b1;
          end
          MODE2: begin
            if (r_gate_reload || (r_ce == WIDTH'(1))) begin
              r_ce          <= w_cr;
              r_out         <= 1'b1;
              r_gate_reload <= 1'b0;
            end else if (r_ce == WIDTH'(2)) begin
              r_ce  <= WIDTH'(1);
              r_out <= 1'b0;
            end else begin
              r_ce <= r_ce - WIDTH'(1);
            end
          end
          MODE3: begin
            if (r_gate_reload || w_m3_zero) begin
              r_ce          <= w_cr;
              r_odd         <= w_cr[0];
              r_first       <= 1'b1;
              r_out         <= r_gate_reload ? 1'b1 : ~r_out;
              r_gate_reload <= 1'b0;
            end else begin
              r_ce    <= w_m3_next;
              r_first <= 1'b0;
            end
          end
          default: ;
        endcase
      end
      if (r_mode == MODE0 && (w_wr_done || w_wr_first)) r_out <= 1'b0;
      if (!gate && w_sq_mode) begin
        r_out <= 1'b1;
        if (r_state != ST_IDLE) r_gate_reload <= 1'b1;
      end
    end
  end

  // Gate low forces OUT high in modes 2/3 without waiting for the clock
  assign out = r_out || (!gate && w_sq_mode);

endmodule
